// File: rtl/neuron_accumulate_pkg.sv
// Shared types and the requantization rule for the neuron datapath.
// Used by the accumulator and by any later stage that narrows a wide sum.
package neuron_accumulate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned RQ_W = 64;

   // Arithmetic shift (floor), optional ReLU, then saturate to an n-bit signed range.
   // Works on a 64-bit container so any accumulator up to 64 bits fits.
   function automatic logic signed [RQ_W-1:0] requant(
      input logic signed [RQ_W-1:0] acc,
      input int unsigned            shift,
      input logic                   relu,
      input int unsigned            n
   );
      logic signed [RQ_W-1:0] s;
      logic signed [RQ_W-1:0] hi;
      logic signed [RQ_W-1:0] lo;
      s  = acc >>> shift;
      hi = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (relu && (s < 64'sd0)) s = 64'sd0;
      if (s > hi)      s = hi;
      else if (s < lo) s = lo;
      return s;
   endfunction

endpackage

// File: rtl/neuron_accumulate_if.sv
// Pair stream in, requantized result out; the accumulator is the slave side.
interface neuron_accumulate_if #(
   parameter int N = 16
);
   logic signed [2*N-1:0] bias_i;
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic signed [N-1:0]   value_i;
   logic signed [N-1:0]   weight_i;
   logic                  last_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic signed [N-1:0]   out_o;

   modport slave (
      input  bias_i, in_valid_i, value_i, weight_i, last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_o
   );

   modport master (
      output bias_i, in_valid_i, value_i, weight_i, last_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_o
   );
endinterface

// File: rtl/neuron_accumulate_requant_relu_sat.sv
// Combinational 2N -> N requantizer: shift, optional ReLU, saturate.
module requant_relu_sat
   import neuron_accumulate_pkg::*;
#(
   parameter int N     = 16,
   parameter int SHIFT = 8,
   parameter int RELU  = 1
) (
   input  logic signed [2*N-1:0] acc_i,
   output logic signed [N-1:0]   res_o
);

   assign res_o = N'(requant(RQ_W'(acc_i), SHIFT, RELU != 0, N));

endmodule

// File: rtl/neuron_accumulate.sv
// Streaming dot product for one neuron: bias + sum(value*weight), requantized on last.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | no vector in progress; next beat loads bias
//   ST_ACC  | vector in progress; beats add to the accumulator
//   ST_DONE | result held on out_o until out_ready_i
module neuron_accumulate
   import neuron_accumulate_pkg::*;
#(
   parameter int N     = 16,
   parameter int SHIFT = 8,
   parameter int RELU  = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   neuron_accumulate_if.slave bus
);

   state_t                state_q, state_d;
   logic signed [2*N-1:0] acc_q, acc_d, prod;
   logic signed [N-1:0]   out_q, rq_res;
   logic                  load_out;
   logic                  beat;

   // Ready depends on state only, so out_ready_i never reaches in_ready_o combinationally.
   assign bus.in_ready_o  = (state_q != ST_DONE);
   assign bus.out_valid_o = (state_q == ST_DONE);
   assign bus.out_o       = out_q;

   assign beat = bus.in_valid_i && bus.in_ready_o;
   assign prod = (2*N)'(bus.value_i) * (2*N)'(bus.weight_i);

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      load_out = 1'b0;
      case (state_q)
         ST_IDLE, ST_ACC: begin
            if (beat) begin
               acc_d = ((state_q == ST_IDLE) ? bus.bias_i : acc_q) + prod;
               if (bus.last_i) begin
                  state_d  = ST_DONE;
                  load_out = 1'b1;
               end else begin
                  state_d = ST_ACC;
               end
            end
         end
         ST_DONE: begin
            if (bus.out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Requantize the sum that includes the final beat.
   requant_relu_sat #(
      .N     (N),
      .SHIFT (SHIFT),
      .RELU  (RELU)
   ) u_requant (
      .acc_i (acc_d),
      .res_o (rq_res)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         if (load_out) out_q <= rq_res;
      end
   end

endmodule

// File: tb/tb_neuron_accumulate.sv
// Bench for neuron_accumulate: two instances (ReLU on/off) share one stimulus
// stream and are compared every cycle against a vector-level model.
module tb_neuron_accumulate;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic signed [31:0]  bias = '0;
   logic                in_valid = 1'b0;
   logic signed [15:0]  value = '0;
   logic signed [15:0]  weight = '0;
   logic                last = 1'b0;
   logic                out_ready = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   neuron_accumulate_if #(.N(16)) if_r1 ();
   neuron_accumulate_if #(.N(16)) if_r0 ();

   assign if_r1.bias_i      = bias;
   assign if_r1.in_valid_i  = in_valid;
   assign if_r1.value_i     = value;
   assign if_r1.weight_i    = weight;
   assign if_r1.last_i      = last;
   assign if_r1.out_ready_i = out_ready;
   assign if_r0.bias_i      = bias;
   assign if_r0.in_valid_i  = in_valid;
   assign if_r0.value_i     = value;
   assign if_r0.weight_i    = weight;
   assign if_r0.last_i      = last;
   assign if_r0.out_ready_i = out_ready;

   neuron_accumulate #(.N(16), .SHIFT(8), .RELU(1)) u_r1 (
      .clk_i (clk), .rst_i (rst), .bus (if_r1)
   );
   neuron_accumulate #(.N(16), .SHIFT(8), .RELU(0)) u_r0 (
      .clk_i (clk), .rst_i (rst), .bus (if_r0)
   );

   // Vector-level model: running sum, held result, and whether a result is pending.
   bit in_vec = 1'b0;
   bit m_hold = 1'b0;
   int m_sum  = 0;
   int m_out1 = 0;
   int m_out0 = 0;

   function automatic int rq(input int a, input bit relu);
      longint s;
      s = longint'(a) >>> 8;
      if (relu && s < 0) s = 0;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return int'(s);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         in_vec = 1'b0;
         m_hold = 1'b0;
         m_sum  = 0;
         m_out1 = 0;
         m_out0 = 0;
      end else if (m_hold) begin
         if (out_ready) m_hold = 1'b0;
      end else if (in_valid) begin
         m_sum  = int'((in_vec ? longint'(m_sum) : longint'(bias))
                       + longint'(value) * longint'(weight));
         in_vec = 1'b1;
         if (last) begin
            in_vec = 1'b0;
            m_hold = 1'b1;
            m_out1 = rq(m_sum, 1'b1);
            m_out0 = rq(m_sum, 1'b0);
         end
      end
   end

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("r1_in_ready",  64'(if_r1.in_ready_o),  64'(!m_hold));
         check("r1_out_valid", 64'(if_r1.out_valid_o), 64'(m_hold));
         check("r1_out",       64'(if_r1.out_o),       64'(m_out1));
         check("r0_in_ready",  64'(if_r0.in_ready_o),  64'(!m_hold));
         check("r0_out_valid", 64'(if_r0.out_valid_o), 64'(m_hold));
         check("r0_out",       64'(if_r0.out_o),       64'(m_out0));
      end
   end

   task automatic beat(input int b, input int v, input int w, input bit l,
                       output int acc_cyc);
      bias     = 32'(b);
      value    = 16'(v);
      weight   = 16'(w);
      last     = l;
      in_valid = 1'b1;
      acc_cyc  = -1;
      for (int i = 0; i < 50; i++) begin
         if (!m_hold) begin
            @(posedge clk); #1;
            acc_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      last     = 1'b0;
      if (acc_cyc < 0) begin
         total++; bad++;
         $display("FAIL beat_timeout: got no accept want accept within 50 cycles");
      end
   endtask

   task automatic take(input int hold, input int e1, input int e0, input string name);
      for (int i = 0; i < 50 && !m_hold; i++) begin
         @(posedge clk); #1;
      end
      check({name, "_valid"}, 64'(if_r1.out_valid_o), 64'd1);
      check({name, "_r1"}, 64'(if_r1.out_o), 64'(e1));
      check({name, "_r0"}, 64'(if_r0.out_o), 64'(e0));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, "_hold_ready"}, 64'(if_r1.in_ready_o), 64'd0);
         check({name, "_hold_out"},   64'(if_r0.out_o),      64'(e0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_ready_after"}, 64'(if_r1.in_ready_o), 64'd1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_valid", 64'(if_r1.out_valid_o), 64'd0);
      check("rst_ready", 64'(if_r1.in_ready_o),  64'd1);
      check("rst_out1",  64'(if_r1.out_o),       64'd0);
      check("rst_out0",  64'(if_r0.out_o),       64'd0);
   endtask

   initial begin
      int c, ca, cb;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      check("reset_ready", 64'(if_r1.in_ready_o), 64'd1);

      beat(0, 256, 256, 1'b0, c);
      beat(0, 256, 256, 1'b1, c);
      check("latency_valid", 64'(if_r1.out_valid_o), 64'd1);
      take(0, 512, 512, "two_beat");

      beat(1280, 0, 0, 1'b1, c);
      take(0, 5, 5, "bias_only");

      beat(0, -256, 256, 1'b1, c);
      take(0, 0, -256, "negative");

      beat(0, 32767, 32767, 1'b1, c);
      take(0, 32767, 32767, "pos_sat");

      beat(0, -32768, 32767, 1'b1, c);
      take(0, 0, -32768, "neg_sat");

      // -1000 + 200 - 35 + 9 = -826; floor(-826/256) = -4
      beat(-1000, 10, 20, 1'b0, c);
      repeat (2) @(posedge clk);
      #1;
      beat(7777, -5, 7, 1'b0, c);
      repeat (2) @(posedge clk);
      #1;
      beat(7777, 3, 3, 1'b1, c);
      take(5, 0, -4, "gapped");

      beat(5000, 100, 100, 1'b0, c);
      beat(5000, 100, 100, 1'b0, c);
      pulse_reset();
      beat(0, 256, 256, 1'b1, c);
      take(0, 256, 256, "after_reset");

      beat(0, 256, 256, 1'b1, c);
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();

      out_ready = 1'b1;
      beat(0, 256, 256, 1'b1, ca);
      beat(0, 16, 16, 1'b1, cb);
      check("b2b_spacing", 64'(cb - ca), 64'd2);
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("b2b_idle_ready", 64'(if_r0.in_ready_o), 64'd1);

      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/neuron_accumulate.md
# neuron_accumulate

Streaming dot-product stage for one neuron of the fully-connected layers. It accepts a valid/ready stream of (activation, weight) pairs terminated by a last flag, and accumulates bias + Σ value·weight in a 2N-bit two's-complement register. On the last pair it requantizes the sum to N bits (arithmetic shift, optional ReLU, saturation) and presents the result on a held valid/ready output. It sits between the weight/activation fetch logic and the next layer's input buffer.

## Interface
- N, default 16: signed width of activation, weight and output; accumulator and bias are 2N.
- SHIFT, default 8: right-shift applied to the accumulator at requantization; range 0..2N-1.
- RELU, default 1: 1 clamps negative results to 0; 0 passes signed results.
- clk_i  in  1  single clock; all logic is on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- bias_i  in  2N signed  bias; sampled only on the first accepted beat of a vector.
- in_valid_i  in  1  input pair valid.
- in_ready_o  out  1  block can accept a pair.
- value_i  in  N signed  activation.
- weight_i  in  N signed  weight.
- last_i  in  1  marks the final pair of the vector.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- out_o  out  N signed  requantized result.

## Operation
- States: IDLE (no vector in progress), ACC (vector in progress), DONE (result held).
- Beat accepted = in_valid_i && in_ready_o. in_ready_o = 1 in IDLE and ACC, 0 in DONE.
- IDLE, beat accepted: acc <= bias_i + value_i·weight_i; next state ACC, or DONE if last_i.
- ACC, beat accepted: acc <= acc + value_i·weight_i; next state stays ACC, or DONE if last_i. bias_i ignored.
- IDLE/ACC with in_valid_i low: acc and state hold (gaps allowed anywhere in a vector).
- Entering DONE: out_o register loads requant(sum) where sum is the acc value including the last beat.
- DONE: out_valid_o = 1; out_o held stable. When out_ready_i = 1, next state IDLE.
- Product: full 2N-bit signed product. Accumulation wraps modulo 2^(2N) without detection.
- requant: s = acc >>> SHIFT (arithmetic, floor toward -inf); if RELU and s < 0 then s = 0; saturate s to [-2^(N-1), 2^(N-1)-1].
- Single-beat vector (last_i on first beat): result = requant(bias + v·w).

## Timing
- Reset (rst_i high at an edge): state IDLE, acc = 0, out_o = 0, out_valid_o = 0, in_ready_o = 1 in the following cycle. Reset mid-vector or in DONE discards everything; next accepted beat starts a new vector with bias.
- Latency: last beat accepted at edge t, out_valid_o high from cycle t+1.
- Throughput: one pair per cycle within a vector; one bubble cycle minimum per vector (DONE lasts at least one cycle, in_ready_o low).
- Output handshake at edge t: in_ready_o high from cycle t+1; out_valid_o low from t+1.
- No combinational path from out_ready_i to in_ready_o; in_ready_o is a function of state only.
- out_o/out_valid_o registered.

## Structure
- Shared package: state enum (IDLE, ACC, DONE), and a function computing requant(acc, SHIFT, RELU, N) including saturation limits.
- One sub-module is natural: requant_relu_sat, combinational 2N→N requantizer, reused by later pooling/output stages.
- Accumulator and multiplier inline; no other sub-modules.

## Test plan
- Defaults; bias 0; beats (256,256), (256,256,last) -> one cycle after last, out_valid_o=1, out_o=512.
- bias 1280; single beat (0,0,last) -> out_o=5; bias 0, single beat (-256,256,last) -> out_o=0; same with RELU=0 -> out_o=-256.
- bias 0; single beat (32767,32767,last) -> out_o=32767 (positive saturation); RELU=0, (-32768,32767,last) -> out_o=-32768.
- Vector of 3 beats with in_valid_i low for 2 cycles between beats, then out_ready_i low 5 cycles -> out_o constant, in_ready_o=0 throughout DONE; out_ready_i high -> in_ready_o=1 next cycle.
- Two beats accepted, rst_i pulsed one cycle, then bias 0, (256,256,last) -> out_o=256 (no residue); all outputs at reset values during the cycle after reset.
- Back-to-back vectors with out_ready_i tied high: second vector's first beat accepted exactly two cycles after first vector's last beat.
